// File: rtl/pipe_selector_n.sv
// pipe_selector_n: N-way WIDTH-bit selector feeding one registered output slot
// with valid/ready flow control. The channel is picked either by an explicit
// index (MODE 0) or by a round-robin search among valid channels (MODE 1).
module pipe_selector_n #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = 0,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  input  logic [SEL_W-1:0]   sel,
  input  logic               flush,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_ch,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SEL_W-1:0] cand;
  logic             grant;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] rr_ptr;
  logic             free;
  logic             accept;
  logic [WIDTH-1:0] word;

  logic             vld_p0;
  logic [WIDTH-1:0] data_p0;
  logic [SEL_W-1:0] ch_p0;

  // Candidate channel and whether it may be granted this cycle.
  // Round-robin walks the offsets backwards so the smallest offset from
  // rr_ptr+1 is the last (winning) assignment.
  always_comb begin
    cand  = '0;
    grant = 1'b0;
    idx   = '0;
    if (MODE == 0) begin
      cand = sel;
      for (int i = 0; i < N; i++) begin
        if (sel == SEL_W'(i)) grant = in_valid[i];
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        idx = SEL_W'((int'(rr_ptr) + k) % N);
        if (in_valid[idx]) begin
          grant = 1'b1;
          cand  = idx;
        end
      end
    end
  end

  assign free   = !vld_p0 || out_ready;
  assign accept = rst_n && grant && free && !flush;

  // Word of the candidate channel and the one-hot handshake back to it.
  always_comb begin
    word     = '0;
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (cand == SEL_W'(i)) begin
        word        = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = accept;
      end
    end
  end

  // Stage p0: output slot; holds under back-pressure, cleared by flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      ch_p0   <= '0;
      rr_ptr  <= SEL_W'(N - 1);
    end else if (accept) begin
      vld_p0  <= 1'b1;
      data_p0 <= word;
      ch_p0   <= cand;
      if (MODE == 1) rr_ptr <= cand;
    end else if (flush || out_ready) begin
      vld_p0  <= 1'b0;
    end
  end

  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign out_ch    = ch_p0;

endmodule

// File: tb/tb_pipe_selector_n.sv
// tb_pipe_selector_n: three instances (explicit select N=4, round-robin N=4,
// explicit select N=3) checked by directed scenarios and a randomized run
// against a behavioural model of the selection rules.
module tb_pipe_selector_n;

  typedef struct {
    bit          vld;
    logic [31:0] data;
    int          ch;
    int          ptr;
  } mstate_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance a: MODE 0, N 4
  logic [127:0] a_data;
  logic [3:0]   a_valid, a_in_ready;
  logic [1:0]   a_sel, a_out_ch;
  logic         a_flush, a_out_valid, a_out_ready;
  logic [31:0]  a_out_data;
  // Instance b: MODE 1, N 4
  logic [127:0] b_data;
  logic [3:0]   b_valid, b_in_ready;
  logic [1:0]   b_sel, b_out_ch;
  logic         b_flush, b_out_valid, b_out_ready;
  logic [31:0]  b_out_data;
  // Instance c: MODE 0, N 3
  logic [95:0]  c_data;
  logic [2:0]   c_valid, c_in_ready;
  logic [1:0]   c_sel, c_out_ch;
  logic         c_flush, c_out_valid, c_out_ready;
  logic [31:0]  c_out_data;

  pipe_selector_n #(.WIDTH(32), .N(4), .MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .sel(a_sel),
    .flush(a_flush), .in_ready(a_in_ready), .out_data(a_out_data), .out_ch(a_out_ch),
    .out_valid(a_out_valid), .out_ready(a_out_ready));

  pipe_selector_n #(.WIDTH(32), .N(4), .MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .sel(b_sel),
    .flush(b_flush), .in_ready(b_in_ready), .out_data(b_out_data), .out_ch(b_out_ch),
    .out_valid(b_out_valid), .out_ready(b_out_ready));

  pipe_selector_n #(.WIDTH(32), .N(3), .MODE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid), .sel(c_sel),
    .flush(c_flush), .in_ready(c_in_ready), .out_data(c_out_data), .out_ch(c_out_ch),
    .out_valid(c_out_valid), .out_ready(c_out_ready));

  int tests = 0;
  int fails = 0;
  mstate_t ma, mb, mc;

  // Which channel the selection rules pick, and whether anything is picked.
  function automatic void ref_pick(input int n, input int mode, input int sel_v,
                                   input logic [3:0] vld, input int ptr,
                                   output int cand, output bit grant);
    grant = 1'b0;
    cand  = 0;
    if (mode == 0) begin
      cand  = sel_v;
      grant = (sel_v < n) && (vld[sel_v] === 1'b1);
    end else begin
      for (int k = 1; k <= n; k++) begin
        int c;
        c = (ptr + k) % n;
        if (!grant && vld[c] === 1'b1) begin
          grant = 1'b1;
          cand  = c;
        end
      end
    end
  endfunction

  function automatic logic [3:0] ref_ready(input int n, input int mode, input mstate_t s,
                                           input bit rst, input bit fl, input bit ordy,
                                           input int sel_v, input logic [3:0] vld);
    int cand;
    bit g;
    ref_pick(n, mode, sel_v, vld, s.ptr, cand, g);
    if (rst && g && (!s.vld || ordy) && !fl) return 4'(1 << cand);
    return 4'b0000;
  endfunction

  function automatic mstate_t ref_next(input int n, input int mode, input mstate_t s,
                                       input bit rst, input bit fl, input bit ordy,
                                       input int sel_v, input logic [3:0] vld,
                                       input logic [127:0] dat);
    mstate_t r;
    int cand;
    bit g;
    r = s;
    ref_pick(n, mode, sel_v, vld, s.ptr, cand, g);
    if (!rst) begin
      r.vld = 1'b0; r.data = '0; r.ch = 0; r.ptr = n - 1;
    end else if (g && (!s.vld || ordy) && !fl) begin
      r.vld = 1'b1; r.data = dat[cand*32 +: 32]; r.ch = cand;
      if (mode == 1) r.ptr = cand;
    end else if (fl || ordy) begin
      r.vld = 1'b0;
    end
    return r;
  endfunction

  // One clock edge; models advance from the inputs present at that edge.
  task automatic tick();
    mstate_t na, nb, nc;
    na = ref_next(4, 0, ma, rst_n, a_flush, a_out_ready, int'(a_sel), a_valid, a_data);
    nb = ref_next(4, 1, mb, rst_n, b_flush, b_out_ready, int'(b_sel), b_valid, b_data);
    nc = ref_next(3, 0, mc, rst_n, c_flush, c_out_ready, int'(c_sel), {1'b0, c_valid},
                  {32'h0, c_data});
    @(posedge clk);
    #1;
    ma = na; mb = nb; mc = nc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 4'hF; b_valid = 4'hF; c_valid = 3'h7;
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
    #1;
    tests++;
    if (a_in_ready !== 4'b0 || b_in_ready !== 4'b0 || c_in_ready !== 3'b0) begin
      fails++;
      $display("FAIL reset_in_ready: got a=%b b=%b c=%b expected all zero", a_in_ready, b_in_ready, c_in_ready);
    end
    tick();
    tick();
    tests++;
    if ({a_out_valid, a_out_data, a_out_ch} !== 35'd0 || {b_out_valid, b_out_data, b_out_ch} !== 35'd0
        || {c_out_valid, c_out_data, c_out_ch} !== 35'd0) begin
      fails++;
      $display("FAIL reset_outputs: got a=%b/%h/%0d b=%b/%h/%0d c=%b/%h/%0d expected 0/0/0",
               a_out_valid, a_out_data, a_out_ch, b_out_valid, b_out_data, b_out_ch,
               c_out_valid, c_out_data, c_out_ch);
    end
    a_valid = 4'h0; b_valid = 4'h0; c_valid = 3'h0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mode0_basic();
    a_sel = 2'd2; a_valid = 4'b0100; a_out_ready = 1'b1;
    #1;
    tests++;
    if (a_in_ready !== 4'b0100) begin
      fails++; $display("FAIL m0_in_ready: got %b expected 0100", a_in_ready);
    end
    tick();
    tests++;
    if (a_out_valid !== 1'b1 || a_out_data !== 32'h22 || a_out_ch !== 2'd2) begin
      fails++;
      $display("FAIL m0_out: got v=%b d=%h ch=%0d expected v=1 d=22 ch=2", a_out_valid, a_out_data, a_out_ch);
    end
    a_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0; a_sel = 2'd1; a_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (a_in_ready !== 4'b0000) begin
        fails++; $display("FAIL bp_in_ready[%0d]: got %b expected 0000", i, a_in_ready);
      end
      tick();
      tests++;
      if (a_out_valid !== 1'b1 || a_out_data !== 32'h22 || a_out_ch !== 2'd2) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h ch=%0d expected v=1 d=22 ch=2", i, a_out_valid, a_out_data, a_out_ch);
      end
    end
    a_out_ready = 1'b1;
    #1;
    tests++;
    if (a_in_ready !== 4'b0010) begin
      fails++; $display("FAIL bp_release_ready: got %b expected 0010", a_in_ready);
    end
    tick();
    tests++;
    if (a_out_valid !== 1'b1 || a_out_data !== 32'h11 || a_out_ch !== 2'd1) begin
      fails++;
      $display("FAIL bp_release_out: got v=%b d=%h ch=%0d expected v=1 d=11 ch=1", a_out_valid, a_out_data, a_out_ch);
    end
    a_valid = 4'b0000;
    tick();
  endtask

  task automatic test_rr_fairness();
    int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
    int exp_pair[2] = '{3, 1};
    b_valid = 4'b1111; b_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      tests++;
      if (b_in_ready !== 4'(1 << exp_seq[i])) begin
        fails++; $display("FAIL rr_ready[%0d]: got %b expected channel %0d", i, b_in_ready, exp_seq[i]);
      end
      tick();
      tests++;
      if (b_out_valid !== 1'b1 || int'(b_out_ch) != exp_seq[i]) begin
        fails++; $display("FAIL rr_ch[%0d]: got v=%b ch=%0d expected ch=%0d", i, b_out_valid, b_out_ch, exp_seq[i]);
      end
    end
    b_valid = 4'b1010;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (int'(b_out_ch) != exp_pair[i] || b_out_data !== 32'(exp_pair[i] * 32'h11)) begin
        fails++;
        $display("FAIL rr_sparse[%0d]: got ch=%0d d=%h expected ch=%0d", i, b_out_ch, b_out_data, exp_pair[i]);
      end
    end
    b_valid = 4'b0000;
    tick();
  endtask

  task automatic test_flush();
    b_valid = 4'b0001; b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0; b_flush = 1'b1; b_valid = 4'b0011;
    #1;
    tests++;
    if (b_in_ready !== 4'b0000) begin
      fails++; $display("FAIL flush_in_ready: got %b expected 0000", b_in_ready);
    end
    tick();
    tests++;
    if (b_out_valid !== 1'b0) begin
      fails++; $display("FAIL flush_clear: got out_valid=%b expected 0", b_out_valid);
    end
    b_flush = 1'b0; b_out_ready = 1'b1;
    #1;
    tests++;
    if (b_in_ready !== 4'b0010) begin
      fails++; $display("FAIL flush_ptr_kept: got %b expected 0010", b_in_ready);
    end
    tick();
    tests++;
    if (b_out_valid !== 1'b1 || b_out_ch !== 2'd1 || b_out_data !== 32'h11) begin
      fails++;
      $display("FAIL flush_next: got v=%b ch=%0d d=%h expected v=1 ch=1 d=11", b_out_valid, b_out_ch, b_out_data);
    end
    b_valid = 4'b0000;
    tick();
  endtask

  task automatic test_out_of_range();
    c_sel = 2'd3; c_valid = 3'b111; c_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++;
      if (c_in_ready !== 3'b000) begin
        fails++; $display("FAIL oor_ready[%0d]: got %b expected 000", i, c_in_ready);
      end
      tick();
      tests++;
      if (c_out_valid !== 1'b0) begin
        fails++; $display("FAIL oor_valid[%0d]: got %b expected 0", i, c_out_valid);
      end
    end
    c_sel = 2'd2;
    #1;
    tests++;
    if (c_in_ready !== 3'b100) begin
      fails++; $display("FAIL top_sel_ready: got %b expected 100", c_in_ready);
    end
    tick();
    tests++;
    if (c_out_valid !== 1'b1 || c_out_data !== 32'h22 || c_out_ch !== 2'd2) begin
      fails++;
      $display("FAIL top_sel_out: got v=%b d=%h ch=%0d expected v=1 d=22 ch=2", c_out_valid, c_out_data, c_out_ch);
    end
    c_valid = 3'b000;
    tick();
  endtask

  task automatic test_reset_mid();
    b_valid = 4'b0100; b_out_ready = 1'b0;
    tick();
    tests++;
    if (b_out_valid !== 1'b1 || b_out_ch !== 2'd2) begin
      fails++; $display("FAIL rm_setup: got v=%b ch=%0d expected v=1 ch=2", b_out_valid, b_out_ch);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (b_in_ready !== 4'b0000) begin
      fails++; $display("FAIL rm_ready_in_reset: got %b expected 0000", b_in_ready);
    end
    tick();
    rst_n = 1'b1;
    tests++;
    if (b_out_valid !== 1'b0 || b_out_data !== 32'h0 || b_out_ch !== 2'd0) begin
      fails++;
      $display("FAIL rm_cleared: got v=%b d=%h ch=%0d expected 0/0/0", b_out_valid, b_out_data, b_out_ch);
    end
    b_valid = 4'b1111; b_out_ready = 1'b1;
    #1;
    tests++;
    if (b_in_ready !== 4'b0001) begin
      fails++; $display("FAIL rm_first_grant: got %b expected 0001", b_in_ready);
    end
    tick();
    tests++;
    if (b_out_valid !== 1'b1 || b_out_ch !== 2'd0 || b_out_data !== 32'h0) begin
      fails++;
      $display("FAIL rm_after: got v=%b ch=%0d d=%h expected v=1 ch=0 d=0", b_out_valid, b_out_ch, b_out_data);
    end
    b_valid = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    logic [3:0] er;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      a_data = {$urandom, $urandom, $urandom, $urandom};
      b_data = {$urandom, $urandom, $urandom, $urandom};
      c_data = {$urandom, $urandom, $urandom};
      a_valid = 4'($urandom); b_valid = 4'($urandom); c_valid = 3'($urandom);
      a_sel = 2'($urandom); b_sel = 2'($urandom); c_sel = 2'($urandom);
      a_flush = ($urandom_range(0, 7) == 0); b_flush = ($urandom_range(0, 7) == 0);
      c_flush = ($urandom_range(0, 7) == 0);
      a_out_ready = ($urandom_range(0, 2) != 0); b_out_ready = ($urandom_range(0, 2) != 0);
      c_out_ready = ($urandom_range(0, 2) != 0);
      #1;
      tests++;
      er = ref_ready(4, 0, ma, rst_n, a_flush, a_out_ready, int'(a_sel), a_valid);
      if (a_in_ready !== er) begin
        fails++; $display("FAIL rnd_a_ready@%0d: got %b expected %b", cyc, a_in_ready, er);
      end
      tests++;
      er = ref_ready(4, 1, mb, rst_n, b_flush, b_out_ready, int'(b_sel), b_valid);
      if (b_in_ready !== er) begin
        fails++; $display("FAIL rnd_b_ready@%0d: got %b expected %b", cyc, b_in_ready, er);
      end
      tests++;
      er = ref_ready(3, 0, mc, rst_n, c_flush, c_out_ready, int'(c_sel), {1'b0, c_valid});
      if ({1'b0, c_in_ready} !== er) begin
        fails++; $display("FAIL rnd_c_ready@%0d: got %b expected %b", cyc, c_in_ready, er[2:0]);
      end
      tick();
      tests++;
      if (a_out_valid !== ma.vld || a_out_data !== ma.data || int'(a_out_ch) != ma.ch) begin
        fails++;
        $display("FAIL rnd_a_out@%0d: got v=%b d=%h ch=%0d expected v=%b d=%h ch=%0d",
                 cyc, a_out_valid, a_out_data, a_out_ch, ma.vld, ma.data, ma.ch);
      end
      tests++;
      if (b_out_valid !== mb.vld || b_out_data !== mb.data || int'(b_out_ch) != mb.ch) begin
        fails++;
        $display("FAIL rnd_b_out@%0d: got v=%b d=%h ch=%0d expected v=%b d=%h ch=%0d",
                 cyc, b_out_valid, b_out_data, b_out_ch, mb.vld, mb.data, mb.ch);
      end
      tests++;
      if (c_out_valid !== mc.vld || c_out_data !== mc.data || int'(c_out_ch) != mc.ch) begin
        fails++;
        $display("FAIL rnd_c_out@%0d: got v=%b d=%h ch=%0d expected v=%b d=%h ch=%0d",
                 cyc, c_out_valid, c_out_data, c_out_ch, mc.vld, mc.data, mc.ch);
      end
    end
  endtask

  initial begin
    ma = '{vld: 1'b0, data: 32'h0, ch: 0, ptr: 3};
    mb = '{vld: 1'b0, data: 32'h0, ch: 0, ptr: 3};
    mc = '{vld: 1'b0, data: 32'h0, ch: 0, ptr: 2};
    rst_n = 1'b0;
    a_data = {32'h33, 32'h22, 32'h11, 32'h00};
    b_data = {32'h33, 32'h22, 32'h11, 32'h00};
    c_data = {32'h22, 32'h11, 32'h00};
    a_valid = '0; b_valid = '0; c_valid = '0;
    a_sel = '0; b_sel = '0; c_sel = '0;
    a_flush = 1'b0; b_flush = 1'b0; c_flush = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_mode0_basic();
    test_backpressure();
    test_rr_fairness();
    test_flush();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_selector_n.md
# pipe_selector_n

Parametrised N-way, WIDTH-bit selector with a registered output stage and valid/ready flow control, for pipeline CPU datapath steering: forwarding sources, writeback source merge, shared-port arbitration. One channel is picked per cycle, either by an explicit select index or by a round-robin arbiter. The picked word is captured into a single output register that honours downstream back-pressure and a pipeline flush.

## Interface
- WIDTH, 32, data width per channel
- N, 4, number of input channels (2..16)
- MODE, 0, 0 = explicit select by `sel`; 1 = round-robin among valid channels
- SEL_W, derived localparam = clog2(N) (minimum 1), width of channel indices

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_data  in  N*WIDTH  channel i occupies [i*WIDTH +: WIDTH]
- in_valid  in  N  channel i offers a word
- sel  in  SEL_W  channel index; used only when MODE=0
- flush  in  1  discard the registered word; block acceptance this cycle
- in_ready  out  N  one-hot or zero; in_ready[i] means the word on channel i is taken this cycle
- out_data  out  WIDTH  registered selected word
- out_ch  out  SEL_W  index of the channel that supplied out_data
- out_valid  out  1  out_data/out_ch hold a word
- out_ready  in  1  consumer accepts the word this cycle

## Operation
- **Slot free:** free = !out_valid || out_ready.
- **Grant, MODE 0:**
  - cand = sel.
  - Grant occurs when sel < N and in_valid[sel].
  - sel >= N (N not a power of two) never grants.
- **Grant, MODE 1:**
  - Search the channels starting at (rr_ptr+1) mod N, in increasing index order with wrap-around.
  - The first channel with in_valid set is the candidate.
  - No valid channel means no grant.
- **Accept:** accept = grant && free && !flush.
  - in_ready[cand] = accept.
  - All other in_ready bits are 0.
  - in_ready may depend combinationally on in_valid. Senders must not make in_valid depend on in_ready.
- **On accept:**
  - out_data <= chosen word, out_ch <= cand, out_valid <= 1.
  - MODE 1 only: rr_ptr <= cand.
- **No accept, out_ready=1:** out_valid <= 0. out_data and out_ch hold their old values.
- **No accept, out_ready=0:** all output registers hold.
- **Flush:**
  - out_valid <= 0 next cycle, regardless of out_ready.
  - No accept in that cycle, so in_ready = 0.
  - rr_ptr is unchanged.
  - Flush has priority over everything except reset.
- **rr_ptr:** internal, SEL_W bits. It changes only on an accepted transfer.
- **Stability:** while out_valid=1 and out_ready=0, out_data and out_ch must not change.

## Timing
- **Reset:** rst_n=0 sampled on an edge sets:
  - out_valid=0, out_data=0, out_ch=0
  - rr_ptr=N-1, so channel 0 has first priority
  - in_ready is 0 in every cycle while rst_n=0
  - Reset mid-transfer drops the held word without a handshake.
- **Latency:** 1 cycle. A word accepted at edge k is visible at the outputs after edge k.
- **Throughput:** 1 word/cycle while out_ready=1. Back-to-back accept and drain in the same cycle is required when out_valid=1 and out_ready=1.
- **Flush and stall together:** flush=1 with out_ready=0 still clears out_valid. The held word is lost by design.
- **Simultaneous valid, MODE 1:** fairness is guaranteed. With all N valid and out_ready=1, grants rotate 0,1,...,N-1,0,...
- **Purely combinational paths:** in_valid/sel/flush/out_ready -> in_ready. There is no combinational path to out_data, out_ch or out_valid.

## Test plan
- **Reset, then MODE 0 basic:**
  - Stimulus: N=4, WIDTH=32, in_data={D3..D0}={0x33,0x22,0x11,0x00}, sel=2, in_valid=4'b0100, out_ready=1.
  - Response: in_ready=4'b0100. Next cycle out_valid=1, out_data=0x22, out_ch=2. After reset all outputs are 0.
- **Back-pressure:**
  - Stimulus: hold out_ready=0 for 3 cycles with out_valid=1, out_data=0x22, and a new channel 1 offer.
  - Response: in_ready=0 throughout; out_data stays 0x22. When out_ready=1, the channel 1 word is accepted in that cycle and out_data=0x11 the next cycle.
- **Round-robin fairness:**
  - Stimulus: MODE=1, in_valid=4'b1111, out_ready=1 for 6 cycles.
  - Response: out_ch sequence 0,1,2,3,0,1.
  - Stimulus: in_valid=4'b1010 from rr_ptr=1.
  - Response: grant 3, then 1.
- **Flush:**
  - Stimulus: flush=1 while out_valid=1, out_ready=0, in_valid=4'b0001.
  - Response: in_ready=0; next cycle out_valid=0; rr_ptr unchanged, so the next grant is the same channel.
- **Out-of-range select:**
  - Stimulus: N=3, sel=3, in_valid=3'b111.
  - Response: in_ready=0, out_valid stays 0.
- **Reset mid-operation:**
  - Stimulus: rst_n=0 for one edge while out_valid=1, MODE=1, rr_ptr=2.
  - Response: out_valid=0, out_data=0. The next grant with all channels valid is channel 0.
